write_buffer_16b: RTL and testbench

//  Posted write buffer + memory-port arbiter between the 16-bit direct-mapped cache and main memory.

---
 rtl/write_buffer_16b.sv | 157 +++++++++++++++
 tb/tb_write_buffer_16b.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_buffer_16b.sv
// Posted write buffer and memory-port arbiter between the direct-mapped cache and main memory.
// Buffers write-through stores, drains them FIFO-order, and services cache-miss reads with forwarding.
module write_buffer_16b #(
    parameter int unsigned DEPTH_LOG2 = 2,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 16
) (
    input  logic              clk,
    input  logic              rstz,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              re,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              rd_busy,
    output logic              full,
    output logic              empty,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    inout  wire               dvdd,
    inout  wire               dgnd
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {StIdle, StWrite, StRead} state_t;

    state_t                  state_q;
    logic [ADDR_W-1:0]       buf_addr [DEPTH];
    logic [DATA_W-1:0]       buf_data [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q;
    logic [CNT_W-1:0]        count_q;
    logic [CNT_W-1:0]        count_d;
    logic [ADDR_W-1:0]       rd_addr_q;

    logic                    push;
    logic                    pop;
    logic                    rd_accept;
    logic                    rd_miss;
    logic                    fwd_hit;
    logic [DATA_W-1:0]       fwd_data;
    logic [DEPTH_LOG2-1:0]   fwd_idx;

    // Supply pins carry no logic; folded here only so they are referenced.
    logic unused_supply;
    assign unused_supply = dvdd ^ dgnd;

    assign push      = we && !full;
    assign pop       = (state_q == StWrite) && mem_ack;
    assign rd_accept = re && !rd_busy;
    assign rd_miss   = rd_accept && !fwd_hit;
    assign count_d   = count_q + CNT_W'(push) - CNT_W'(pop);

    // Scan oldest to youngest so the last match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_idx = rd_ptr_q + DEPTH_LOG2'(i);
            if ((CNT_W'(i) < count_q) && (buf_addr[fwd_idx] == addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = buf_data[fwd_idx];
            end
        end
        // Store and read share the addr port, so an accepted store always matches.
        if (push) begin
            fwd_hit  = 1'b1;
            fwd_data = data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr[wr_ptr_q] <= addr;
            buf_data[wr_ptr_q] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_addr_q <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            rd_busy   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            rd_valid <= 1'b0;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full    <= (count_d == CNT_W'(DEPTH));
            empty   <= (count_d == '0);

            if (rd_accept) begin
                if (fwd_hit) begin
                    rd_data  <= fwd_data;
                    rd_valid <= 1'b1;
                end else begin
                    rd_busy   <= 1'b1;
                    rd_addr_q <= addr;
                end
            end

            unique case (state_q)
                StIdle: begin
                    // A pending miss goes ahead of buffered writes; forwarding keeps this safe.
                    if (rd_miss || rd_busy) begin
                        state_q  <= StRead;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= rd_miss ? addr : rd_addr_q;
                    end else if (!empty) begin
                        state_q   <= StWrite;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= buf_addr[rd_ptr_q];
                        mem_wdata <= buf_data[rd_ptr_q];
                    end
                end
                StWrite: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StRead: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        rd_data  <= mem_rdata;
                        rd_valid <= 1'b1;
                        rd_busy  <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_write_buffer_16b.sv
// Randomised scoreboard bench for write_buffer_16b: a read must return the latest store to its address,
// writes must reach memory in store order, and the req/ack handshake must stay well-formed.
module tb_write_buffer_16b;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rstz = 1'b0;
    logic        we = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] data_in = '0;
    logic        re = 1'b0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        rd_busy;
    logic        full;
    logic        empty;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    wire         dvdd = 1'b1;
    wire         dgnd = 1'b0;

    write_buffer_16b dut (
        .clk       (clk),
        .rstz      (rstz),
        .we        (we),
        .addr      (addr),
        .data_in   (data_in),
        .re        (re),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_busy   (rd_busy),
        .full      (full),
        .empty     (empty),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .dvdd      (dvdd),
        .dgnd      (dgnd)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    ent_t        wq[$];
    logic [15:0] rdq[$];
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] mem_model [logic [15:0]];
    logic        model_busy = 1'b0;
    logic [15:0] model_rd_addr = '0;
    logic        exp_rv = 1'b0;
    logic        cur_we = 1'b0;
    bit          ack_hold = 1'b0;
    int          force_delay = -1;
    int          req_age = 0;
    int          delay = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] dflt(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
    endfunction

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        return mem_model.exists(a) ? mem_model[a] : dflt(a);
    endfunction

    // Monitor: every rd_valid pulse consumes one expected read result.
    always @(negedge clk) begin
        if (rstz && rd_valid) begin
            if (rdq.size() == 0) chk("rd_unexpected", 32'(rdq.size()), 32'd1);
            else chk("rd_data", {16'h0, rd_data}, {16'h0, rdq.pop_front()});
        end
    end

    // One clock of stimulus: check status, play the memory, then drive inputs and update the model.
    task automatic step(input logic w, input logic r, input logic [15:0] a, input logic [15:0] d);
        logic acc, hit, wr_ack, rd_ack, busy_before;
        @(negedge clk);
        chk("full", full, wq.size() == DEPTH);
        chk("empty", empty, wq.size() == 0);
        chk("rd_busy", rd_busy, model_busy);
        chk("rd_valid", rd_valid, exp_rv);
        wr_ack = 1'b0;
        rd_ack = 1'b0;
        mem_rdata = 16'($urandom);
        if (mem_ack) begin
            mem_ack = 1'b0;
            chk("req_gap", mem_req, 1'b0);
            req_age = 0;
        end else if (mem_req) begin
            if (req_age == 0) begin
                cur_we = mem_we;
                if (mem_we) begin
                    chk("wr_req_nonempty", wq.size() != 0, 1'b1);
                    chk("read_priority", model_busy, 1'b0);
                end else begin
                    chk("rd_req_expected", model_busy, 1'b1);
                end
                delay = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 4));
            end
            chk("mem_we_stable", mem_we, cur_we);
            if (cur_we && wq.size() != 0) begin
                chk("wr_addr", mem_addr, wq[0].a);
                chk("wr_data", mem_wdata, wq[0].d);
            end else if (!cur_we) begin
                chk("rd_addr", mem_addr, model_rd_addr);
            end
            if (!ack_hold && req_age >= delay) begin
                mem_ack = 1'b1;
                if (cur_we) wr_ack = 1'b1;
                else begin
                    rd_ack = 1'b1;
                    mem_rdata = mem_rd(mem_addr);
                end
            end
            req_age++;
        end

        we = w;
        re = r;
        addr = a;
        data_in = d;
        busy_before = model_busy;
        acc = w && (wq.size() < DEPTH);
        hit = acc;
        if (r && !busy_before) foreach (wq[i]) if (wq[i].a == a) hit = 1'b1;
        if (acc) begin
            wq.push_back('{a: a, d: d});
            ref_mem[a] = d;
        end
        if (wr_ack && wq.size() != 0) begin
            mem_model[wq[0].a] = wq[0].d;
            void'(wq.pop_front());
        end
        if (r && !busy_before) begin
            rdq.push_back(ref_rd(a));
            if (!hit) begin
                model_busy = 1'b1;
                model_rd_addr = a;
            end
        end
        exp_rv = (r && !busy_before && hit) || rd_ack;
        if (rd_ack) model_busy = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic clear_model();
        wq.delete();
        rdq.delete();
        ref_mem = mem_model;
        model_busy = 1'b0;
        exp_rv = 1'b0;
        req_age = 0;
        mem_ack = 1'b0;
        we = 1'b0;
        re = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_data", rd_data, 16'h0000);
        chk("rst_rd_busy", rd_busy, 1'b0);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        rstz = 1'b1;
        idle(2);

        // Single store, ack after 3 request cycles
        force_delay = 3;
        step(1'b1, 1'b0, 16'h0010, 16'hBEEF);
        idle(8);
        force_delay = -1;

        // Fill to full with memory stalled; the fifth store must be dropped
        ack_hold = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 16'h0100 + 16'(i), 16'h1000 + 16'(i));
        idle(2);
        ack_hold = 1'b0;
        idle(30);

        // Youngest buffered store is forwarded
        ack_hold = 1'b1;
        step(1'b1, 1'b0, 16'h0020, 16'h0011);
        step(1'b1, 1'b0, 16'h0020, 16'h0022);
        step(1'b0, 1'b1, 16'h0020, 16'h0000);
        idle(2);
        ack_hold = 1'b0;
        idle(20);

        // Read miss overtakes buffered writes
        mem_model[16'h0030] = 16'hCAFE;
        ref_mem[16'h0030] = 16'hCAFE;
        ack_hold = 1'b1;
        step(1'b1, 1'b0, 16'h0050, 16'h0001);
        step(1'b1, 1'b0, 16'h0052, 16'h0002);
        step(1'b0, 1'b1, 16'h0030, 16'h0000);
        idle(2);
        ack_hold = 1'b0;
        idle(30);

        // Reset in the middle of a write handshake
        ack_hold = 1'b1;
        step(1'b1, 1'b0, 16'h0070, 16'h1234);
        idle(3);
        @(negedge clk);
        rstz = 1'b0;
        #1;
        chk("midrst_mem_req", mem_req, 1'b0);
        chk("midrst_empty", empty, 1'b1);
        chk("midrst_rd_busy", rd_busy, 1'b0);
        clear_model();
        repeat (2) @(negedge clk);
        rstz = 1'b1;
        ack_hold = 1'b0;
        idle(10);

        // Random traffic over a small address window
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 9) < 6), ($urandom_range(0, 3) == 0),
                 16'h0040 + 16'($urandom_range(0, 7)), 16'($urandom));
        end

        // Drain with a bounded wait
        begin
            int n = 0;
            while ((wq.size() != 0 || model_busy || rdq.size() != 0) && n < 300) begin
                step(1'b0, 1'b0, 16'h0, 16'h0);
                n++;
            end
            chk("drain_done", n < 300, 1'b1);
        end
        idle(5);
        chk("end_rdq_empty", 32'(rdq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
